button_input_register: RTL and testbench

Parametrised, multi-channel front-end for the push-button controls (increase, decrease, function-select and any added buttons) feeding the clock/alarm control FSM. Each channel is synchronised, debounced and converted into a registered stable level plus a one-cycle press pulse with optional auto-repeat while the button is held. A shared `chip_select` gate decides whether results reach the outputs (load) or the outputs freeze (hold). This replaces the fixed 3-bit hold/load register.

---
 rtl/button_pkg.sv | 23 ++
 rtl/button_channel.sv | 102 ++++++++++
 rtl/button_input_register.sv | 69 ++++++
 tb/tb_button_input_register.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg
//   Shared constants for the push-button front-end: default timing parameters,
//   channel index names used by the clock/alarm control FSM, and a helper that
//   sizes counters.
package button_pkg;

    localparam int DEF_N_CH            = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 0;   // 0 = auto-repeat disabled
    localparam int DEF_REPEAT_PERIOD   = 1;

    // Channel indices into btn_in / out_level / out_pulse.
    localparam int BTN_INC  = 0;
    localparam int BTN_DEC  = 1;
    localparam int BTN_FUNC = 2;

    // Bits needed to hold 0..max_val, never less than one bit so that a
    // degenerate parameter still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel
//   One button path: 2-flop synchroniser -> debouncer -> press / auto-repeat
//   event generator.
//   Ports:
//     clk, reset  : system clock, asynchronous active-high reset
//     btn_raw     : raw button level, asynchronous to clk, 1 = pressed
//     stable      : debounced level
//     evt         : one-cycle event on press and on each auto-repeat
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic stable,
    output logic evt
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(REPEAT_DELAY);
    localparam int PER_W  = cnt_width(REPEAT_PERIOD - 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPEAT_PERIOD - 1);
    localparam bit                REPEAT_EN = (REPEAT_DELAY > 0);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic              stable_dly_q, stable_dly_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic              at_delay;
    logic              press;
    logic              rpt;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;

        // Debounce: the count survives only while the synced level keeps
        // disagreeing with stable; any agreement (a bounce back) restarts it.
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Hold counter saturates at REPEAT_DELAY so it can never wrap into a
        // spurious event; after that the period counter paces the repeats.
        // Both are held at zero while released, so a press starts from zero.
        at_delay   = (hold_cnt_q == HOLD_MAX);
        hold_cnt_d = '0;
        per_cnt_d  = '0;
        if (REPEAT_EN && stable_q) begin
            if (!at_delay) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q;
                per_cnt_d  = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
            end
        end

        press = stable_q & ~stable_dly_q;
        rpt   = REPEAT_EN && stable_q && at_delay && (per_cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            per_cnt_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            per_cnt_q    <= per_cnt_d;
        end
    end

    assign stable = stable_q;
    assign evt    = press | rpt;

endmodule

// File: rtl/button_input_register.sv
// button_input_register
//   Multi-channel push-button front-end for the clock/alarm control FSM.
//   Each channel is synchronised, debounced and turned into a stable level
//   plus press/auto-repeat pulses; chip_select gates the output register.
//   Ports:
//     clk, reset  : system clock, asynchronous active-high reset
//     btn_in      : raw button levels (N_CH), 1 = pressed
//     chip_select : 1 = load new results, 0 = freeze level, suppress pulses
//     out_level   : registered debounced level per channel
//     out_pulse   : registered one-cycle event per channel
module button_input_register
    import button_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic            chip_select,
    output logic [N_CH-1:0] out_level,
    output logic [N_CH-1:0] out_pulse
);

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] evt;
    logic [N_CH-1:0] out_level_q, out_level_d;
    logic [N_CH-1:0] out_pulse_q, out_pulse_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_in[i]),
            .stable  (stable[i]),
            .evt     (evt[i])
        );
    end

    // Events arriving while deselected are dropped rather than queued.
    always_comb begin
        out_level_d = out_level_q;
        out_pulse_d = '0;
        if (chip_select) begin
            out_level_d = stable;
            out_pulse_d = evt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_level_q <= '0;
            out_pulse_q <= '0;
        end else begin
            out_level_q <= out_level_d;
            out_pulse_q <= out_pulse_d;
        end
    end

    assign out_level = out_level_q;
    assign out_pulse = out_pulse_q;

endmodule

// File: tb/tb_button_input_register.sv
module tb_button_input_register;

    localparam int N_CH = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] btn_in = '0;
    logic            chip_select = 1'b1;
    logic [N_CH-1:0] out_level;
    logic [N_CH-1:0] out_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // number of rising edges seen so far

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] pulse;
    } exp_t;

    exp_t sb[$];

    button_input_register #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .chip_select (chip_select),
        .out_level   (out_level),
        .out_pulse   (out_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [N_CH-1:0] p);
        exp_t e;
        e.cyc   = c;
        e.pulse = p;
        sb.push_back(e);
    endtask

    // Advance k cycles; at each falling edge retire due scoreboard entries
    // and flag any pulse nobody expected.
    task automatic run_cycles(input int k);
        exp_t e;
        repeat (k) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (out_pulse !== e.pulse) begin
                    errors++;
                    $display("FAIL pulse@%0d: got %b want %b", cyc, out_pulse, e.pulse);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL pulse_missed@%0d: got none want %b", e.cyc, e.pulse);
            end else if (out_pulse !== '0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected@%0d: got %b want 000", cyc, out_pulse);
            end
        end
    endtask

    task automatic test_reset();
        run_cycles(3);
        checks++;
        if (out_level !== '0 || out_pulse !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b want 000/000", out_level, out_pulse);
        end
        btn_in = '1;
        run_cycles(8);
        checks++;
        if (out_level !== '0) begin
            errors++;
            $display("FAIL reset_held_press: got %b want 000", out_level);
        end
        btn_in = '0;
        run_cycles(3);
        reset = 1'b0;
        run_cycles(8);
        checks++;
        if (out_level !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want 000", out_level);
        end
    endtask

    task automatic test_clean_press();
        int n;
        n = cyc;
        btn_in[0] = 1'b1;
        push(n + 7, 3'b001);
        run_cycles(6);
        checks++;
        if (out_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_early: got %b want 0", out_level[0]);
        end
        run_cycles(1);
        checks++;
        if (out_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_rise: got %b want 1", out_level[0]);
        end
        btn_in[0] = 1'b0;
        run_cycles(6);
        checks++;
        if (out_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_release_early: got %b want 1", out_level[0]);
        end
        run_cycles(1);
        checks++;
        if (out_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_fall: got %b want 0", out_level[0]);
        end
        run_cycles(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clean_sb_empty: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_bounce();
        int f;
        for (int s = 0; s < 6; s++) begin
            btn_in[0] = (s % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                run_cycles(1);
                checks++;
                if (out_level[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_level@%0d: got %b want 0", cyc, out_level[0]);
                end
            end
        end
        btn_in[0] = 1'b1;
        f = cyc;
        push(f + 7, 3'b001);
        run_cycles(6);
        checks++;
        if (out_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle_early: got %b want 0", out_level[0]);
        end
        run_cycles(1);
        checks++;
        if (out_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_settle_level: got %b want 1", out_level[0]);
        end
        btn_in[0] = 1'b0;
        run_cycles(12);
        checks++;
        if (out_level[0] !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bounce_done: got level %b pending %0d want 0/0", out_level[0], sb.size());
        end
    endtask

    task automatic test_repeat();
        int t;
        t = cyc + 7;
        btn_in[1] = 1'b1;
        push(t,      3'b010);
        push(t + 8,  3'b010);
        push(t + 11, 3'b010);
        push(t + 14, 3'b010);
        push(t + 17, 3'b010);
        run_cycles(20);
        btn_in[1] = 1'b0;
        run_cycles(27);
        checks++;
        if (out_level[1] !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL repeat_done: got level %b pending %0d want 0/0", out_level[1], sb.size());
        end
    endtask

    task automatic test_hold_cs();
        chip_select = 1'b0;
        btn_in[2]   = 1'b1;
        for (int j = 0; j < 8; j++) begin
            run_cycles(1);
            checks++;
            if (out_level[2] !== 1'b0) begin
                errors++;
                $display("FAIL hold_level@%0d: got %b want 0", cyc, out_level[2]);
            end
        end
        btn_in[2] = 1'b0;
        run_cycles(1);
        checks++;
        if (out_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL hold_level_late: got %b want 0", out_level[2]);
        end
        chip_select = 1'b1;
        run_cycles(1);
        checks++;
        if (out_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL hold_load_level: got %b want 1", out_level[2]);
        end
        run_cycles(4);
        checks++;
        if (out_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL hold_level_kept: got %b want 1", out_level[2]);
        end
        run_cycles(1);
        checks++;
        if (out_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got %b want 0", out_level[2]);
        end
        run_cycles(8);
    endtask

    task automatic test_reset_mid();
        int r;
        btn_in[1] = 1'b1;
        push(cyc + 7, 3'b010);
        run_cycles(7);
        checks++;
        if (out_level[1] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre_level: got %b want 1", out_level[1]);
        end
        btn_in[0] = 1'b1;
        run_cycles(3);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_level !== '0 || out_pulse !== '0) begin
            errors++;
            $display("FAIL rmid_async: got %b/%b want 000/000", out_level, out_pulse);
        end
        run_cycles(2);
        r = cyc;
        reset = 1'b0;
        push(r + 7, 3'b011);
        run_cycles(6);
        checks++;
        if (out_level !== 3'b000) begin
            errors++;
            $display("FAIL rmid_redebounce: got %b want 000", out_level);
        end
        run_cycles(1);
        checks++;
        if (out_level !== 3'b011) begin
            errors++;
            $display("FAIL rmid_level: got %b want 011", out_level);
        end
        btn_in = '0;
        run_cycles(10);
        checks++;
        if (out_level !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rmid_done: got level %b pending %0d want 000/0", out_level, sb.size());
        end
    endtask

    task automatic test_simultaneous();
        btn_in = 3'b011;
        push(cyc + 7, 3'b011);
        run_cycles(7);
        checks++;
        if (out_level !== 3'b011) begin
            errors++;
            $display("FAIL simul_level: got %b want 011", out_level);
        end
        btn_in = '0;
        run_cycles(10);
        checks++;
        if (out_level !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL simul_done: got level %b pending %0d want 000/0", out_level, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_hold_cs();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
